tinker_exec_unit: RTL and testbench
===================================

// Module: tinker_exec_unit
// PURPOSE
//  Clocked, parametrised execute stage for the Tinker core: decodes one 32-bit instruction per handshake,
//  reads/writes an internal register file and runs integer, logic, shift and move ops in 1 cycle.
//  Integer divide is a multi-cycle iterative (radix-2 restoring) unit.
//  Sits between the fetch stage (instr_* handshake) and the writeback/trace logic (result_* outputs).
// PARAMETERS
//  XLEN    64  datapath and register width (power of 2, 8..64)
//  NREGS   32  architectural registers (2..32); rd/rs/rt >= NREGS -> illegal
//  FP_LAT  3   float-op latency in cycles (only used with TINKER_FPU_EN; >= 1)
// PORTS
//  clk           in   1          clock, all state on rising edge
//  reset         in   1          synchronous, active-high
//  instr_valid   in   1          instruction presented
//  instr_ready   out  1          unit can accept (high only in IDLE)
//  instruction   in   32         [31:27] op, [26:22] rd, [21:17] rs, [16:12] rt, [11:0] L
//  result_valid  out  1          one-cycle pulse per accepted instruction
//  result_rd     out  5          destination of retired instruction
//  result_data   out  XLEN       value written (0 when illegal)
//  illegal       out  1          qualifies result_valid: opcode/reg index not supported, no write
//  dbg_addr      in   5          debug register read address
//  dbg_data      out  XLEN       combinational read of regs[dbg_addr] (0 if >= NREGS)
// BEHAVIOUR
//  - Reset: regs all 0; state IDLE; instr_ready=0 in reset cycle, 1 after; result_valid, result_rd, result_data,
//    illegal = 0. Reset mid-divide/mid-FP aborts: no register write, no result_valid.
//  - Accept = instr_valid & instr_ready at rising edge. Operands read combinationally from regs at accept.
//  - Ops (unsigned): 0x18 add rs+rt; 0x19 addi rd+L; 0x1a sub rs-rt; 0x1b subi rd-L; 0x1c mul (low XLEN bits);
//    0x1d div rs/rt; 0x00 and; 0x01 or; 0x02 xor; 0x03 not ~rs; 0x04 shftr rs>>rt; 0x05 shftri rd>>L;
//    0x06 shftl rs<<rt; 0x07 shftli rd<<L; 0x11 mov rs; 0x12 movi L. L zero-extended to XLEN.
//    Shift amount = low $clog2(XLEN) bits of operand. Anything else illegal.
//  - r0 reads 0; writes to r0 discarded but still retire (result_data shows computed value).
//  - Single-cycle ops: regs[rd] written on accept edge; result_valid high the next cycle (latency 1);
//    instr_ready stays high -> back-to-back issue, no hazard (next op sees updated regs).
//  - FSM: IDLE -> DIV on accepted div; DIV runs XLEN iterations (one per edge); on XLEN-th edge after accept
//    writes rd, returns to IDLE, result_valid high next cycle (latency XLEN+1 = 65 at default).
//    instr_ready=0 throughout DIV. Divide by zero: quotient all-ones, no trap, illegal=0.
//  - Illegal: accepted normally, no write, result_valid=1 with illegal=1 and result_data=0 next cycle.
//  - instr_valid while instr_ready=0 is ignored; sender holds instruction until accepted.
//  - Outputs are registered; result_* hold last value when result_valid=0, except illegal cleared.
// CONFIGURATION
//  TINKER_FPU_EN defined: 0x14 addf, 0x15 subf, 0x16 mulf, 0x17 divf on IEEE-754 double (XLEN must be 64);
//    state FP, instr_ready=0, write + return to IDLE on FP_LAT-th edge after accept, result_valid next cycle.
//    Simulation model via $bitstoreal/$realtobits.
//  TINKER_FPU_EN undefined: 0x14..0x17 are illegal; no FP state or real-typed logic compiled.
// TESTING
//  1 reset, movi r1,5; movi r2,7; add r3,r1,r2 back-to-back -> three pulses, result_data=5,7,12, dbg r3=12
//  2 r1=100, r2=7, div r3,r1,r2 -> instr_ready low 64 cycles, result_valid exactly 65 cycles after accept, 14
//  3 div by zero (r2=0) -> result_data=64'hFFFF_FFFF_FFFF_FFFF, illegal=0; r3 updated
//  4 opcode 0x1f and rd=0 add -> illegal=1/data 0 for 0x1f; r0 still reads 0 after add
//  5 r1=1, shftli r1,L=63 -> 64'h8000_0000_0000_0000; shftr with rt=64 -> shift by 0, value unchanged
//  6 assert reset 10 cycles into div -> no result_valid, r3 and all regs 0, instr_ready=1 after reset

Source files
------------

// File: rtl/tinker_exec_unit.sv
// -----------------------------------------------------------------------------
// tinker_exec_unit
//
// Execute stage for the Tinker core. Accepts one 32-bit instruction per
// instr_valid/instr_ready handshake, reads operands from an internal register
// file and retires a result one cycle after acceptance for integer, logic,
// shift and move ops. Unsigned divide runs on an iterative radix-2 restoring
// divider (one quotient bit per clock, XLEN clocks).
//
// Optional feature macro: TINKER_FPU_EN
//   defined   -> ops 0x14..0x17 (addf/subf/mulf/divf) on IEEE-754 doubles,
//                simulation model only, result after FP_LAT clocks (XLEN = 64)
//   undefined -> those opcodes retire as illegal; no FP state is built
//
// Instruction format: [31:27] op, [26:22] rd, [21:17] rs, [16:12] rt, [11:0] L
//
// Ports
//   clk           in   clock, all state on rising edge
//   reset         in   synchronous, active-high
//   instr_valid   in   instruction presented
//   instr_ready   out  unit can accept (only while idle)
//   instruction   in   32-bit instruction word
//   result_valid  out  one-cycle pulse per retired instruction
//   result_rd     out  destination of the retired instruction
//   result_data   out  value written (0 when illegal)
//   illegal       out  qualifies result_valid; no register was written
//   dbg_addr      in   debug register read address
//   dbg_data      out  combinational read of regs[dbg_addr] (0 if out of range)
//
// FSM states
//   state  | meaning
//   S_IDLE | ready for a new instruction, single-cycle ops retire here
//   S_DIV  | restoring divide in progress, one quotient bit per clock
//   S_FP   | (TINKER_FPU_EN only) waiting out the FP latency
// -----------------------------------------------------------------------------
module tinker_exec_unit #(
  parameter int XLEN   = 64,
  parameter int NREGS  = 32,
  parameter int FP_LAT = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instruction,
  output logic            result_valid,
  output logic [4:0]      result_rd,
  output logic [XLEN-1:0] result_data,
  output logic            illegal,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  localparam int SHW     = $clog2(XLEN);
  localparam int CNT_MAX = (XLEN > FP_LAT) ? XLEN : FP_LAT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [4:0] OP_AND    = 5'h00;
  localparam logic [4:0] OP_OR     = 5'h01;
  localparam logic [4:0] OP_XOR    = 5'h02;
  localparam logic [4:0] OP_NOT    = 5'h03;
  localparam logic [4:0] OP_SHFTR  = 5'h04;
  localparam logic [4:0] OP_SHFTRI = 5'h05;
  localparam logic [4:0] OP_SHFTL  = 5'h06;
  localparam logic [4:0] OP_SHFTLI = 5'h07;
  localparam logic [4:0] OP_MOV    = 5'h11;
  localparam logic [4:0] OP_MOVI   = 5'h12;
  localparam logic [4:0] OP_ADD    = 5'h18;
  localparam logic [4:0] OP_ADDI   = 5'h19;
  localparam logic [4:0] OP_SUB    = 5'h1a;
  localparam logic [4:0] OP_SUBI   = 5'h1b;
  localparam logic [4:0] OP_MUL    = 5'h1c;
  localparam logic [4:0] OP_DIV    = 5'h1d;
`ifdef TINKER_FPU_EN
  localparam logic [4:0] OP_ADDF   = 5'h14;
  localparam logic [4:0] OP_SUBF   = 5'h15;
  localparam logic [4:0] OP_MULF   = 5'h16;
  localparam logic [4:0] OP_DIVF   = 5'h17;
`endif

  typedef enum logic [1:0] {
`ifdef TINKER_FPU_EN
    S_FP   = 2'd2,
`endif
    S_IDLE = 2'd0,
    S_DIV  = 2'd1
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic            ready_q;
  logic            res_valid_q;
  logic [4:0]      res_rd_q;
  logic [XLEN-1:0] res_data_q;
  logic            illegal_q;
  logic [CW-1:0]   cnt_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] div_rem_q, div_quo_q, div_dvs_q;

  // ---------------------------------------------------------------------------
  // Decode and operand read
  // ---------------------------------------------------------------------------
  logic [4:0]      op_f, rd_f, rs_f, rt_f;
  logic [11:0]     lit_f;
  logic [XLEN-1:0] imm, rs_val, rt_val, rd_val;

  assign op_f  = instruction[31:27];
  assign rd_f  = instruction[26:22];
  assign rs_f  = instruction[21:17];
  assign rt_f  = instruction[16:12];
  assign lit_f = instruction[11:0];
  assign imm   = XLEN'(lit_f);

  // Entry 0 is never written, so r0 and out-of-range indices both read as 0.
  always_comb begin
    rs_val   = '0;
    rt_val   = '0;
    rd_val   = '0;
    dbg_data = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (int'(rs_f) == i)     rs_val   = regs_q[i];
      if (int'(rt_f) == i)     rt_val   = regs_q[i];
      if (int'(rd_f) == i)     rd_val   = regs_q[i];
      if (int'(dbg_addr) == i) dbg_data = regs_q[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Single-cycle ALU
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] alu_res;
  logic            op_ok, idx_ok, legal, is_div;
`ifdef TINKER_FPU_EN
  logic            is_fp;
`endif

  always_comb begin
    alu_res = '0;
    op_ok   = 1'b1;
    is_div  = 1'b0;
`ifdef TINKER_FPU_EN
    is_fp   = 1'b0;
`endif
    case (op_f)
      OP_ADD:    alu_res = rs_val + rt_val;
      OP_ADDI:   alu_res = rd_val + imm;
      OP_SUB:    alu_res = rs_val - rt_val;
      OP_SUBI:   alu_res = rd_val - imm;
      OP_MUL:    alu_res = rs_val * rt_val;
      OP_DIV:    is_div  = 1'b1;
      OP_AND:    alu_res = rs_val & rt_val;
      OP_OR:     alu_res = rs_val | rt_val;
      OP_XOR:    alu_res = rs_val ^ rt_val;
      OP_NOT:    alu_res = ~rs_val;
      OP_SHFTR:  alu_res = rs_val >> rt_val[SHW-1:0];
      OP_SHFTRI: alu_res = rd_val >> imm[SHW-1:0];
      OP_SHFTL:  alu_res = rs_val << rt_val[SHW-1:0];
      OP_SHFTLI: alu_res = rd_val << imm[SHW-1:0];
      OP_MOV:    alu_res = rs_val;
      OP_MOVI:   alu_res = imm;
`ifdef TINKER_FPU_EN
      OP_ADDF, OP_SUBF, OP_MULF, OP_DIVF: is_fp = 1'b1;
`endif
      default:   op_ok   = 1'b0;
    endcase
  end

  // All three index fields are checked regardless of whether the op uses them.
  assign idx_ok = (int'(rd_f) < NREGS) && (int'(rs_f) < NREGS) && (int'(rt_f) < NREGS);
  assign legal  = op_ok && idx_ok;

  // ---------------------------------------------------------------------------
  // Restoring divide step: shift in the next dividend bit, subtract if it fits.
  // A zero divisor always "fits", which yields the all-ones quotient.
  // ---------------------------------------------------------------------------
  logic [XLEN:0]   div_shift, div_diff;
  logic [XLEN-1:0] div_rem_n, div_quo_n;

  always_comb begin
    div_shift = {div_rem_q, div_quo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, div_dvs_q};
    if (div_diff[XLEN]) begin
      div_rem_n = div_shift[XLEN-1:0];
      div_quo_n = {div_quo_q[XLEN-2:0], 1'b0};
    end else begin
      div_rem_n = div_diff[XLEN-1:0];
      div_quo_n = {div_quo_q[XLEN-2:0], 1'b1};
    end
  end

`ifdef TINKER_FPU_EN
  // ---------------------------------------------------------------------------
  // FP behavioural model, computed at accept and held until retirement.
  // ---------------------------------------------------------------------------
  real             fp_a, fp_b, fp_r;
  logic [XLEN-1:0] fp_calc, fp_res_q;

  always_comb begin
    fp_a = $bitstoreal(rs_val);
    fp_b = $bitstoreal(rt_val);
    fp_r = 0.0;
    case (op_f)
      OP_ADDF: fp_r = fp_a + fp_b;
      OP_SUBF: fp_r = fp_a - fp_b;
      OP_MULF: fp_r = fp_a * fp_b;
      OP_DIVF: fp_r = fp_a / fp_b;
      default: fp_r = 0.0;
    endcase
    fp_calc = $realtobits(fp_r);
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: output / control decode
  // ---------------------------------------------------------------------------
  logic            accept, cnt_last, div_start;
  logic            retire, ret_illegal, wr_en;
  logic [4:0]      wr_rd;
  logic [XLEN-1:0] wr_data;
`ifdef TINKER_FPU_EN
  logic            fp_start;
`endif

  assign accept   = instr_valid && ready_q;
  assign cnt_last = (cnt_q == CW'(1));

  always_comb begin
    div_start   = 1'b0;
    retire      = 1'b0;
    ret_illegal = 1'b0;
    wr_en       = 1'b0;
    wr_rd       = rd_f;
    wr_data     = alu_res;
`ifdef TINKER_FPU_EN
    fp_start    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!legal) begin
            retire      = 1'b1;
            ret_illegal = 1'b1;
          end else if (is_div) begin
            div_start = 1'b1;
`ifdef TINKER_FPU_EN
          end else if (is_fp) begin
            fp_start = 1'b1;
`endif
          end else begin
            retire = 1'b1;
            wr_en  = 1'b1;
          end
        end
      end
      S_DIV: begin
        if (cnt_last) begin
          retire  = 1'b1;
          wr_en   = 1'b1;
          wr_rd   = rd_q;
          wr_data = div_quo_n;
        end
      end
`ifdef TINKER_FPU_EN
      S_FP: begin
        if (cnt_last) begin
          retire  = 1'b1;
          wr_en   = 1'b1;
          wr_rd   = rd_q;
          wr_data = fp_res_q;
        end
      end
`endif
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (div_start) state_d = S_DIV;
`ifdef TINKER_FPU_EN
        else if (fp_start) state_d = S_FP;
`endif
      end
      S_DIV: if (cnt_last) state_d = S_IDLE;
`ifdef TINKER_FPU_EN
      S_FP:  if (cnt_last) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Multi-cycle bookkeeping: down-counter, destination latch, divider datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      rd_q      <= '0;
      div_rem_q <= '0;
      div_quo_q <= '0;
      div_dvs_q <= '0;
    end else begin
      if (div_start) begin
        cnt_q     <= CW'(XLEN);
        rd_q      <= rd_f;
        div_rem_q <= '0;
        div_quo_q <= rs_val;
        div_dvs_q <= rt_val;
`ifdef TINKER_FPU_EN
      end else if (fp_start) begin
        cnt_q <= CW'(FP_LAT);
        rd_q  <= rd_f;
`endif
      end else if (state_q != S_IDLE) begin
        cnt_q <= cnt_q - 1'b1;
        if (state_q == S_DIV) begin
          div_rem_q <= div_rem_n;
          div_quo_q <= div_quo_n;
        end
      end
    end
  end

`ifdef TINKER_FPU_EN
  always_ff @(posedge clk) begin
    if (reset)         fp_res_q <= '0;
    else if (fp_start) fp_res_q <= fp_calc;
  end
`endif

  // ---------------------------------------------------------------------------
  // Register file (r0 never written)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (wr_en && (int'(wr_rd) == i)) regs_q[i] <= wr_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs. Ready follows the next state so it is low during the
  // reset cycle and drops on the same edge that starts a multi-cycle op.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_rd_q    <= '0;
      res_data_q  <= '0;
      illegal_q   <= 1'b0;
    end else begin
      ready_q     <= (state_d == S_IDLE);
      res_valid_q <= retire;
      illegal_q   <= retire && ret_illegal;
      if (retire) begin
        res_rd_q   <= wr_rd;
        res_data_q <= ret_illegal ? '0 : wr_data;
      end
    end
  end

  assign instr_ready  = ready_q;
  assign result_valid = res_valid_q;
  assign result_rd    = res_rd_q;
  assign result_data  = res_data_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_tinker_exec_unit.sv
// Directed bench for tinker_exec_unit (default parameters, FPU disabled).
module tb_tinker_exec_unit;

  localparam int XLEN = 64;

  localparam logic [4:0] OP_XOR    = 5'h02;
  localparam logic [4:0] OP_NOT    = 5'h03;
  localparam logic [4:0] OP_SHFTR  = 5'h04;
  localparam logic [4:0] OP_SHFTRI = 5'h05;
  localparam logic [4:0] OP_SHFTLI = 5'h07;
  localparam logic [4:0] OP_MOVI   = 5'h12;
  localparam logic [4:0] OP_ADDF   = 5'h14;
  localparam logic [4:0] OP_ADD    = 5'h18;
  localparam logic [4:0] OP_SUB    = 5'h1a;
  localparam logic [4:0] OP_SUBI   = 5'h1b;
  localparam logic [4:0] OP_MUL    = 5'h1c;
  localparam logic [4:0] OP_DIV    = 5'h1d;
  localparam logic [4:0] OP_BAD    = 5'h1f;

  logic            clk = 1'b0;
  logic            reset;
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instruction;
  logic            result_valid;
  logic [4:0]      result_rd;
  logic [XLEN-1:0] result_data;
  logic            illegal;
  logic [4:0]      dbg_addr;
  logic [XLEN-1:0] dbg_data;

  int checks = 0;
  int errors = 0;
  int lat, busy, nz, pulses;
  logic [XLEN-1:0] v;

  always #5 clk = ~clk;

  tinker_exec_unit dut (
    .clk          (clk),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instruction  (instruction),
    .result_valid (result_valid),
    .result_rd    (result_rd),
    .result_data  (result_data),
    .illegal      (illegal),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [11:0] l);
    for (int i = 0; i < 200 && !instr_ready; i++) tick;
    chk("issue_ready", 64'(instr_ready), 64'd1);
    instruction = {op, rd, rs, rt, l};
    instr_valid = 1'b1;
    tick;
    instr_valid = 1'b0;
  endtask

  // Called right after issue(): the current cycle is cycle 1 after accept.
  task automatic wait_result(output int lat_o, output int busy_o);
    lat_o  = 1;
    busy_o = 0;
    while (!result_valid && lat_o < 200) begin
      if (!instr_ready) busy_o++;
      tick;
      lat_o++;
    end
    if (!result_valid) lat_o = -1;
  endtask

  task automatic dbg(input logic [4:0] a, output logic [XLEN-1:0] val);
    dbg_addr = a;
    #1;
    val = dbg_data;
  endtask

  initial begin
    reset       = 1'b1;
    instr_valid = 1'b0;
    instruction = '0;
    dbg_addr    = '0;

    // 1: reset state, back-to-back single-cycle ops
    tick;
    tick;
    chk("rst_ready", 64'(instr_ready), 64'd0);
    chk("rst_valid", 64'(result_valid), 64'd0);
    chk("rst_data", result_data, 64'd0);
    chk("rst_rd", 64'(result_rd), 64'd0);
    chk("rst_illegal", 64'(illegal), 64'd0);
    reset = 1'b0;
    tick;
    chk("ready_after_rst", 64'(instr_ready), 64'd1);
    chk("idle_no_pulse", 64'(result_valid), 64'd0);

    issue(OP_MOVI, 5'd1, 5'd0, 5'd0, 12'd5);
    chk("t1_valid0", 64'(result_valid), 64'd1);
    chk("t1_data0", result_data, 64'd5);
    chk("t1_rd0", 64'(result_rd), 64'd1);
    issue(OP_MOVI, 5'd2, 5'd0, 5'd0, 12'd7);
    chk("t1_valid1", 64'(result_valid), 64'd1);
    chk("t1_data1", result_data, 64'd7);
    issue(OP_ADD, 5'd3, 5'd1, 5'd2, 12'd0);
    chk("t1_valid2", 64'(result_valid), 64'd1);
    chk("t1_data2", result_data, 64'd12);
    chk("t1_rd2", 64'(result_rd), 64'd3);
    chk("t1_ready_stays", 64'(instr_ready), 64'd1);
    tick;
    chk("t1_pulse_end", 64'(result_valid), 64'd0);
    chk("t1_data_hold", result_data, 64'd12);
    dbg(5'd3, v);
    chk("t1_dbg_r3", v, 64'd12);

    // 2: 100 / 7 through the divider
    issue(OP_MOVI, 5'd1, 5'd0, 5'd0, 12'd100);
    issue(OP_MOVI, 5'd2, 5'd0, 5'd0, 12'd7);
    issue(OP_DIV, 5'd3, 5'd1, 5'd2, 12'd0);
    chk("t2_ready_low", 64'(instr_ready), 64'd0);
    wait_result(lat, busy);
    chk("t2_latency", 64'(lat), 64'd65);
    chk("t2_busy_cycles", 64'(busy), 64'd64);
    chk("t2_data", result_data, 64'd14);
    chk("t2_rd", 64'(result_rd), 64'd3);
    chk("t2_illegal", 64'(illegal), 64'd0);
    chk("t2_ready_back", 64'(instr_ready), 64'd1);
    dbg(5'd3, v);
    chk("t2_dbg_r3", v, 64'd14);

    // 3: divide by zero
    issue(OP_MOVI, 5'd2, 5'd0, 5'd0, 12'd0);
    issue(OP_DIV, 5'd3, 5'd1, 5'd2, 12'd0);
    wait_result(lat, busy);
    chk("t3_latency", 64'(lat), 64'd65);
    chk("t3_data", result_data, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t3_illegal", 64'(illegal), 64'd0);
    dbg(5'd3, v);
    chk("t3_dbg_r3", v, 64'hFFFF_FFFF_FFFF_FFFF);

    // 4: illegal opcodes and r0 writes
    issue(OP_BAD, 5'd3, 5'd1, 5'd2, 12'd0);
    chk("t4_valid", 64'(result_valid), 64'd1);
    chk("t4_illegal", 64'(illegal), 64'd1);
    chk("t4_data", result_data, 64'd0);
    dbg(5'd3, v);
    chk("t4_no_write", v, 64'hFFFF_FFFF_FFFF_FFFF);
    tick;
    chk("t4_illegal_clr", 64'(illegal), 64'd0);
    chk("t4_valid_clr", 64'(result_valid), 64'd0);
    issue(OP_ADDF, 5'd4, 5'd1, 5'd2, 12'd0);
    chk("t4_fp_illegal", 64'(illegal), 64'd1);
    issue(OP_ADD, 5'd0, 5'd1, 5'd2, 12'd0);
    chk("t4_r0_valid", 64'(result_valid), 64'd1);
    chk("t4_r0_data", result_data, 64'd100);
    chk("t4_r0_rd", 64'(result_rd), 64'd0);
    chk("t4_r0_illegal", 64'(illegal), 64'd0);
    dbg(5'd0, v);
    chk("t4_r0_reads0", v, 64'd0);

    // 5: shifts and assorted ALU ops
    issue(OP_MOVI, 5'd1, 5'd0, 5'd0, 12'd1);
    issue(OP_SHFTLI, 5'd1, 5'd0, 5'd0, 12'd63);
    chk("t5_shftli", result_data, 64'h8000_0000_0000_0000);
    dbg(5'd1, v);
    chk("t5_dbg_r1", v, 64'h8000_0000_0000_0000);
    issue(OP_MOVI, 5'd2, 5'd0, 5'd0, 12'd64);
    issue(OP_SHFTR, 5'd4, 5'd1, 5'd2, 12'd0);
    chk("t5_shftr64", result_data, 64'h8000_0000_0000_0000);
    issue(OP_SHFTRI, 5'd1, 5'd0, 5'd0, 12'd60);
    chk("t5_shftri", result_data, 64'd8);
    issue(OP_MOVI, 5'd5, 5'd0, 5'd0, 12'd3);
    issue(OP_SUBI, 5'd5, 5'd0, 5'd0, 12'd5);
    chk("t5_subi_wrap", result_data, 64'hFFFF_FFFF_FFFF_FFFE);
    issue(OP_NOT, 5'd6, 5'd0, 5'd0, 12'd0);
    chk("t5_not_r0", result_data, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(OP_MOVI, 5'd7, 5'd0, 5'd0, 12'd12);
    issue(OP_MUL, 5'd8, 5'd7, 5'd7, 12'd0);
    chk("t5_mul", result_data, 64'd144);
    issue(OP_XOR, 5'd9, 5'd7, 5'd5, 12'd0);
    chk("t5_xor", result_data, 64'hFFFF_FFFF_FFFF_FFF2);
    issue(OP_SUB, 5'd11, 5'd0, 5'd7, 12'd0);
    chk("t5_sub", result_data, 64'hFFFF_FFFF_FFFF_FFF4);

    // 6: reset in the middle of a divide
    issue(OP_MOVI, 5'd1, 5'd0, 5'd0, 12'd100);
    issue(OP_MOVI, 5'd2, 5'd0, 5'd0, 12'd7);
    issue(OP_DIV, 5'd3, 5'd1, 5'd2, 12'd0);
    repeat (10) tick;
    chk("t6_mid_div_busy", 64'(instr_ready), 64'd0);
    reset = 1'b1;
    tick;
    chk("t6_rst_ready", 64'(instr_ready), 64'd0);
    chk("t6_rst_valid", 64'(result_valid), 64'd0);
    reset = 1'b0;
    tick;
    chk("t6_ready_after", 64'(instr_ready), 64'd1);
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      if (result_valid) pulses++;
      tick;
    end
    chk("t6_no_pulse", 64'(pulses), 64'd0);
    dbg(5'd3, v);
    chk("t6_r3_zero", v, 64'd0);
    nz = 0;
    for (int i = 0; i < 32; i++) begin
      dbg(5'(i), v);
      if (v !== 64'd0) nz++;
    end
    chk("t6_all_regs_zero", 64'(nz), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
